// File: rtl/gstsnd_pkg.sv
// Shared constants for the STE DMA sound sequencer: register indices, FSM states, address width.
// Optional looping playback is enabled with the GSTSND_LOOP_EN macro.
package gstsnd_pkg;

  localparam int GSTSND_ADDR_W = 23;

  localparam logic [3:0] REG_CTRL      = 4'd0;
  localparam logic [3:0] REG_START_HI  = 4'd1;
  localparam logic [3:0] REG_START_MID = 4'd2;
  localparam logic [3:0] REG_START_LO  = 4'd3;
  localparam logic [3:0] REG_CNT_HI    = 4'd4;
  localparam logic [3:0] REG_CNT_MID   = 4'd5;
  localparam logic [3:0] REG_CNT_LO    = 4'd6;
  localparam logic [3:0] REG_END_HI    = 4'd7;
  localparam logic [3:0] REG_END_MID   = 4'd8;
  localparam logic [3:0] REG_END_LO    = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_REQ,
    S_LOAD,
    S_NEXT
  } state_t;

endpackage

// File: rtl/gstsnd_regs.sv
// CPU register file: shadow start/end, control bits, combinational readback of registers and live counter.
// The loop bit exists only when GSTSND_LOOP_EN is defined; otherwise it reads 0.
module gstsnd_regs
  import gstsnd_pkg::*;
#(
  parameter int ADDR_W = GSTSND_ADDR_W
) (
  input  logic              clk32,
  input  logic              reset,
  input  logic              CS,
  input  logic [3:0]        A,
  input  logic              RW,
  input  logic [7:0]        DIN,
  output logic [7:0]        DOUT,
  input  logic [ADDR_W-1:0] counter,
  input  logic              clr_play,
  output logic              play,
  output logic              play_nxt,
  output logic              loop,
  output logic [ADDR_W-1:0] start_sh,
  output logic [ADDR_W-1:0] end_sh
);

  logic wr;
  assign wr = CS && !RW;

  // Registers are word addresses; the CPU sees them as a 24-bit byte address with bit 0 fixed at 0.
  function automatic logic [7:0] get_byte(input logic [ADDR_W-1:0] w, input logic [1:0] sel);
    logic [23:0] b;
    b = 24'({w, 1'b0});
    case (sel)
      2'd2:    return b[23:16];
      2'd1:    return b[15:8];
      default: return b[7:0];
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] set_byte(input logic [ADDR_W-1:0] w, input logic [1:0] sel,
                                                 input logic [7:0] d);
    logic [23:0] b;
    b = 24'({w, 1'b0});
    case (sel)
      2'd2:    b[23:16] = d;
      2'd1:    b[15:8]  = d;
      default: b[7:0]   = d;
    endcase
    return b[ADDR_W:1];
  endfunction

  // A CPU control write overrides the FSM's end-of-frame clear in the same cycle.
  always_comb begin
    play_nxt = play;
    if (clr_play)
      play_nxt = 1'b0;
    if (wr && A == REG_CTRL)
      play_nxt = DIN[0];
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      play     <= 1'b0;
      start_sh <= '0;
      end_sh   <= '0;
    end else begin
      play <= play_nxt;
      if (wr) begin
        case (A)
          REG_START_HI:  start_sh <= set_byte(start_sh, 2'd2, DIN);
          REG_START_MID: start_sh <= set_byte(start_sh, 2'd1, DIN);
          REG_START_LO:  start_sh <= set_byte(start_sh, 2'd0, DIN);
          REG_END_HI:    end_sh   <= set_byte(end_sh, 2'd2, DIN);
          REG_END_MID:   end_sh   <= set_byte(end_sh, 2'd1, DIN);
          REG_END_LO:    end_sh   <= set_byte(end_sh, 2'd0, DIN);
          default: ;
        endcase
      end
    end
  end

`ifdef GSTSND_LOOP_EN
  always_ff @(posedge clk32) begin
    if (reset)
      loop <= 1'b0;
    else if (wr && A == REG_CTRL)
      loop <= DIN[1];
  end
`else
  assign loop = 1'b0;
`endif

  always_comb begin
    DOUT = 8'h00;
    if (CS && RW) begin
      case (A)
        REG_CTRL:      DOUT = {6'd0, loop, play};
        REG_START_HI:  DOUT = get_byte(start_sh, 2'd2);
        REG_START_MID: DOUT = get_byte(start_sh, 2'd1);
        REG_START_LO:  DOUT = get_byte(start_sh, 2'd0);
        REG_CNT_HI:    DOUT = get_byte(counter, 2'd2);
        REG_CNT_MID:   DOUT = get_byte(counter, 2'd1);
        REG_CNT_LO:    DOUT = get_byte(counter, 2'd0);
        REG_END_HI:    DOUT = get_byte(end_sh, 2'd2);
        REG_END_MID:   DOUT = get_byte(end_sh, 2'd1);
        REG_END_LO:    DOUT = get_byte(end_sh, 2'd0);
        default:       DOUT = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/gstsnd_dma.sv
// DMA sound sequencer: fetches one sample word per shifter FIFO request and strobes SLOAD_N.
// GSTSND_LOOP_EN enables looping frames (re-arm at frame end with no idle cycle).
module gstsnd_dma
  import gstsnd_pkg::*;
#(
  parameter int ADDR_W = GSTSND_ADDR_W
) (
  input  logic              clk32,
  input  logic              reset,
  input  logic              CS,
  input  logic [3:0]        A,
  input  logic              RW,
  input  logic [7:0]        DIN,
  output logic [7:0]        DOUT,
  input  logic              SREQ,
  output logic              SLOAD_N,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              sint,
  output logic              frame_end
);

  state_t            state;
  logic [ADDR_W-1:0] counter;
  logic [ADDR_W-1:0] end_act;
  logic [ADDR_W-1:0] cnt_inc;
  logic [ADDR_W-1:0] start_sh;
  logic [ADDR_W-1:0] end_sh;
  logic              empty;
  logic              play;
  logic              play_nxt;
  logic              loop;
  logic              rearm;
  logic              clr_play;

  gstsnd_regs #(.ADDR_W(ADDR_W)) u_regs (
    .clk32    (clk32),
    .reset    (reset),
    .CS       (CS),
    .A        (A),
    .RW       (RW),
    .DIN      (DIN),
    .DOUT     (DOUT),
    .counter  (counter),
    .clr_play (clr_play),
    .play     (play),
    .play_nxt (play_nxt),
    .loop     (loop),
    .start_sh (start_sh),
    .end_sh   (end_sh)
  );

  assign cnt_inc  = counter + ADDR_W'(1);
  assign rearm    = loop && !empty;
  // frame_end is high exactly in the NEXT cycle that closes a frame.
  assign clr_play = (state == S_NEXT) && frame_end && !rearm;
  assign mem_addr = counter;
  assign sint     = (state != S_IDLE);

  always_ff @(posedge clk32) begin
    if (reset) begin
      state     <= S_IDLE;
      counter   <= '0;
      end_act   <= '0;
      empty     <= 1'b0;
      mem_req   <= 1'b0;
      SLOAD_N   <= 1'b1;
      frame_end <= 1'b0;
    end else begin
      SLOAD_N   <= 1'b1;
      frame_end <= 1'b0;
      case (state)
        S_IDLE: if (play_nxt) state <= S_ARM;
        S_ARM: begin
          counter <= start_sh;
          end_act <= end_sh;
          empty   <= (start_sh == end_sh);
          if (start_sh == end_sh) begin
            frame_end <= 1'b1;
            state     <= S_NEXT;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!play) begin
            state <= S_IDLE;
          end else if (SREQ) begin
            mem_req <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            SLOAD_N <= 1'b0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          frame_end <= (cnt_inc == end_act);
          state     <= S_NEXT;
        end
        S_NEXT: begin
          // An empty frame leaves the counter parked on start (== end).
          if (!empty)
            counter <= cnt_inc;
          if (frame_end)
            state <= rearm ? S_ARM : S_IDLE;
          else
            state <= play ? S_WAIT : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
